// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register of the 5-stage MIPS32 pipeline.
// Word loads/stores on an internal data memory; exports write-back and forwarding info.
module mem_wb_stage #(
  parameter int DMEM_ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  EX_MEM_CU_signals,
  input  logic [31:0] EX_MEM_ALU_result,
  input  logic [31:0] EX_MEM_DMEM_wr_data,
  input  logic [4:0]  EX_MEM_wr_addr,
  output logic        EX_MEM_RegWrite,
  output logic [4:0]  EX_MEM_rd_field,
  output logic        MEM_WB_RegWrite,
  output logic [4:0]  MEM_WB_rd_field,
  output logic [31:0] MEM_WB_wr_data,
  output logic        MEM_align_err
);

  localparam int DEPTH = 1 << DMEM_ADDR_W;

  logic                   mem_to_reg;
  logic                   mem_read;
  logic                   mem_write;
  logic                   reg_write;
  logic                   aligned;
  logic [DMEM_ADDR_W-1:0] mem_idx;
  logic [31:0]            rd_word;
  logic                   mem_we;

  logic [31:0] mem_q [DEPTH];

  logic        reg_write_d,  reg_write_q;
  logic        mem_to_reg_d, mem_to_reg_q;
  logic [31:0] load_data_d,  load_data_q;
  logic [31:0] alu_result_d, alu_result_q;
  logic [4:0]  wr_addr_d,    wr_addr_q;
  logic        align_err_d,  align_err_q;

  // Address bits above the word index are deliberately dropped so accesses wrap.
  logic unused_alu_hi;
  assign unused_alu_hi = ^EX_MEM_ALU_result[31:DMEM_ADDR_W+2];

  always_comb begin
    mem_to_reg = EX_MEM_CU_signals[0];
    mem_read   = EX_MEM_CU_signals[1];
    mem_write  = EX_MEM_CU_signals[2];
    reg_write  = EX_MEM_CU_signals[3];
    aligned    = (EX_MEM_ALU_result[1:0] == 2'b00);
    mem_idx    = EX_MEM_ALU_result[DMEM_ADDR_W+1:2];
    rd_word    = mem_q[mem_idx];
    mem_we     = mem_write & aligned;
  end

  always_comb begin
    EX_MEM_RegWrite = reg_write & (EX_MEM_wr_addr != 5'd0);
    EX_MEM_rd_field = EX_MEM_wr_addr;
  end

  always_comb begin
    reg_write_d  = reg_write & (EX_MEM_wr_addr != 5'd0);
    mem_to_reg_d = mem_to_reg;
    load_data_d  = 32'h0;
    if (mem_read && aligned) begin
      load_data_d = rd_word;
    end
    alu_result_d = EX_MEM_ALU_result;
    wr_addr_d    = EX_MEM_wr_addr;
    align_err_d  = align_err_q | ((mem_read | mem_write) & ~aligned);
  end

  // Load captures the pre-write word because the read is taken before this edge's write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (mem_we) begin
      mem_q[mem_idx] <= EX_MEM_DMEM_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      load_data_q  <= 32'h0;
      alu_result_q <= 32'h0;
      wr_addr_q    <= 5'd0;
      align_err_q  <= 1'b0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      load_data_q  <= load_data_d;
      alu_result_q <= alu_result_d;
      wr_addr_q    <= wr_addr_d;
      align_err_q  <= align_err_d;
    end
  end

  always_comb begin
    MEM_WB_RegWrite = reg_write_q;
    MEM_WB_rd_field = wr_addr_q;
    MEM_WB_wr_data  = mem_to_reg_q ? load_data_q : alu_result_q;
    MEM_align_err   = align_err_q;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases plus randomized traffic
// compared against a word-array model of the data memory and MEM/WB behaviour.
module tb_mem_wb_stage;

  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  cu = 4'h0;
  logic [31:0] alu = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [4:0]  waddr = 5'd0;
  logic        ex_rw;
  logic [4:0]  ex_rd;
  logic        wb_rw;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        align_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_mem [DEPTH];
  logic        model_err;

  mem_wb_stage #(.DMEM_ADDR_W(AW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .EX_MEM_CU_signals   (cu),
    .EX_MEM_ALU_result   (alu),
    .EX_MEM_DMEM_wr_data (wdata),
    .EX_MEM_wr_addr      (waddr),
    .EX_MEM_RegWrite     (ex_rw),
    .EX_MEM_rd_field     (ex_rd),
    .MEM_WB_RegWrite     (wb_rw),
    .MEM_WB_rd_field     (wb_rd),
    .MEM_WB_wr_data      (wb_data),
    .MEM_align_err       (align_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    model_err = 1'b0;
  endtask

  // cu bits: [0] MemtoReg, [1] MemRead, [2] MemWrite, [3] RegWrite
  task automatic applyStimulus(input logic [3:0] c, input logic [31:0] a,
                               input logic [31:0] d, input logic [4:0] r);
    int          idx;
    bit          is_aligned;
    logic [31:0] exp_load;
    logic [31:0] exp_wb;
    logic        exp_rw;
    @(negedge clk);
    cu = c; alu = a; wdata = d; waddr = r;
    idx        = int'((a >> 2) % DEPTH);
    is_aligned = (a % 4) == 0;
    exp_rw     = c[3] && (r != 0);
    exp_load   = (c[1] && is_aligned) ? model_mem[idx] : 32'h0;
    exp_wb     = c[0] ? exp_load : a;
    #1;
    checkOutput("ex_regwrite", {31'h0, ex_rw}, {31'h0, exp_rw});
    checkOutput("ex_rd", {27'h0, ex_rd}, {27'h0, r});
    if (c[2] && is_aligned) model_mem[idx] = d;
    if ((c[1] || c[2]) && !is_aligned) model_err = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("wb_regwrite", {31'h0, wb_rw}, {31'h0, exp_rw});
    checkOutput("wb_rd", {27'h0, wb_rd}, {27'h0, r});
    checkOutput("wb_data", wb_data, exp_wb);
    checkOutput("align_err", {31'h0, align_err}, {31'h0, model_err});
  endtask

  // Reset pulse spanning one rising edge while the given EX/MEM inputs are presented.
  task automatic resetWith(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cu = c; alu = a; wdata = d; waddr = 5'd3;
    rst = 1'b1;
    #1;
    checkOutput("rst_wb_rw", {31'h0, wb_rw}, 32'h0);
    checkOutput("rst_wb_rd", {27'h0, wb_rd}, 32'h0);
    checkOutput("rst_wb_data", wb_data, 32'h0);
    checkOutput("rst_err", {31'h0, align_err}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_data", wb_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cu = 4'h0;
    clearModel();
  endtask

  initial begin
    logic [3:0]  rc;
    logic [31:0] ra;
    clearModel();
    $display("[TB] start");
    resetWith(4'h0, 32'h0, 32'h0);

    applyStimulus(4'b0100, 32'h10, 32'hDEADBEEF, 5'd0);
    applyStimulus(4'b1011, 32'h10, 32'h0, 5'd5);
    checkOutput("tp_load_data", wb_data, 32'hDEADBEEF);
    checkOutput("tp_load_rd", {27'h0, wb_rd}, 32'd5);

    applyStimulus(4'b1000, 32'h0000_1234, 32'h0, 5'd9);
    checkOutput("tp_rtype_data", wb_data, 32'h1234);
    applyStimulus(4'b1000, 32'h55, 32'h0, 5'd0);
    checkOutput("tp_rd0_rw", {31'h0, wb_rw}, 32'h0);

    applyStimulus(4'b0100, 32'h20, 32'h11, 5'd0);
    applyStimulus(4'b0100, 32'h22, 32'h5, 5'd0);
    checkOutput("tp_misalign_err", {31'h0, align_err}, 32'h1);
    applyStimulus(4'b1011, 32'h20, 32'h0, 5'd7);
    checkOutput("tp_misalign_mem", wb_data, 32'h11);
    applyStimulus(4'b1011, 32'h21, 32'h0, 5'd7);
    checkOutput("tp_misalign_load", wb_data, 32'h0);

    applyStimulus(4'b0100, (32'd4 << AW) + 32'd8, 32'hA5A5A5A5, 5'd0);
    applyStimulus(4'b1011, 32'h8, 32'h0, 5'd2);
    checkOutput("tp_wrap", wb_data, 32'hA5A5A5A5);

    applyStimulus(4'b0100, 32'h30, 32'h1111, 5'd0);
    applyStimulus(4'b0110, 32'h30, 32'h2222, 5'd0);
    applyStimulus(4'b1011, 32'h30, 32'h0, 5'd4);
    checkOutput("tp_rw_same", wb_data, 32'h2222);

    resetWith(4'b0100, 32'h4, 32'h77);
    applyStimulus(4'b1011, 32'h4, 32'h0, 5'd6);
    checkOutput("tp_rst_store", wb_data, 32'h0);
    applyStimulus(4'b1011, 32'h10, 32'h0, 5'd6);
    checkOutput("tp_rst_clear", wb_data, 32'h0);
    applyStimulus(4'b0100, 32'h4, 32'h77, 5'd0);
    applyStimulus(4'b1011, 32'h4, 32'h0, 5'd6);
    checkOutput("tp_post_rst_store", wb_data, 32'h77);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) resetWith(4'h0, 32'h0, 32'h0);
      rc = 4'($urandom);
      ra = {24'h0, 4'($urandom_range(0, 15)), 2'b00, 2'b00};
      ra[5:2] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) ra[31:AW+2] = 22'($urandom);
      if ($urandom_range(0, 60) == 0) ra[1:0] = 2'($urandom_range(1, 3));
      applyStimulus(rc, ra, $urandom, 5'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register of the 5-stage MIPS32 pipeline. Consumes the EX/MEM register outputs of the execute stage, performs word loads and stores on an internal data memory, and registers the results into MEM/WB. It drives the write-back data, destination register and RegWrite strobe that feed the register file and the execute-stage forwarding unit. It also exports the EX/MEM-level RegWrite and destination register that the forwarding unit needs.

## Interface
Parameters:
- DMEM_ADDR_W, 8, word-index width; the data memory holds 2^DMEM_ADDR_W 32-bit words.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- EX_MEM_CU_signals  in  4  control bits: [0] MemtoReg, [1] MemRead, [2] MemWrite, [3] RegWrite.
- EX_MEM_ALU_result  in  32  byte address for load/store; ALU result for R/I-type.
- EX_MEM_DMEM_wr_data  in  32  store data (already forwarded).
- EX_MEM_wr_addr  in  5  destination register.
- EX_MEM_RegWrite  out  1  combinational copy of EX_MEM_CU_signals[3], gated to 0 when EX_MEM_wr_addr==0.
- EX_MEM_rd_field  out  5  combinational copy of EX_MEM_wr_addr.
- MEM_WB_RegWrite  out  1  registered RegWrite toward the register file and forwarding unit.
- MEM_WB_rd_field  out  5  registered destination register.
- MEM_WB_wr_data  out  32  write-back data: MEM/WB load data if MEM/WB MemtoReg=1, else MEM/WB ALU result.
- MEM_align_err  out  1  sticky flag set by any misaligned load or store.

## Operation
- Word index = EX_MEM_ALU_result[DMEM_ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo the memory size.
- Aligned means EX_MEM_ALU_result[1:0]==2'b00.
- Store:
  - Triggered by MemWrite=1 and an aligned address.
  - mem[index] <= EX_MEM_DMEM_wr_data at the rising edge.
  - A misaligned store writes nothing.
- Load:
  - Memory read is combinational from mem[index].
  - With MemRead=1 and an aligned address, the read value is captured into MEM/WB at the rising edge.
  - With MemRead=1 and a misaligned address, 32'h0 is captured.
  - With MemRead=0, the captured load field is 32'h0.
- MemRead and MemWrite both set, aligned: the load captures the pre-write contents and the write still commits.
- MEM_align_err:
  - Set at the rising edge when (MemRead|MemWrite)=1 and the address is misaligned.
  - Held until rst.
- MEM/WB register holds 71 bits: {RegWrite_gated, MemtoReg, load_data, ALU_result, wr_addr}.
  - Loaded every cycle; there is no hold or flush input.
  - RegWrite_gated = RegWrite & (wr_addr!=0), so writes to $0 are never issued.
- MEM_WB_wr_data is a 2:1 mux on the MEM/WB register outputs only. It has no path from the EX/MEM inputs.

## Timing
- Reset (asynchronous, immediate):
  - All MEM/WB register fields go to 0, so MEM_WB_RegWrite=0, MEM_WB_rd_field=0 and MEM_WB_wr_data=0.
  - MEM_align_err=0.
  - Every data-memory word goes to 0.
- Reset asserted mid-operation:
  - Any store whose edge coincides with rst high is discarded.
  - The first store after rst deasserts commits normally.
- Store latency: a store present at EX/MEM in cycle N is visible to a load at EX/MEM in cycle N+1.
- Load latency: load data appears on MEM_WB_wr_data one cycle after the load occupies EX/MEM.
- ALU-result latency: same as load latency, one cycle after EX/MEM.
- EX_MEM_RegWrite and EX_MEM_rd_field have zero latency (combinational).
- Back-to-back store then load to the same word returns the newly stored value.
- Load then store to the same word in consecutive cycles: the load returns the old value.

## Test plan
- Reset, then store 32'hDEADBEEF to address 0x10, then load 0x10 next cycle with MemtoReg=1, RegWrite=1, rd=5 -> one cycle after the load: MEM_WB_wr_data=32'hDEADBEEF, MEM_WB_rd_field=5, MEM_WB_RegWrite=1.
- R-type pass-through: ALU_result=32'h0000_1234, MemtoReg=0, RegWrite=1, rd=9 -> EX_MEM_RegWrite=1 and EX_MEM_rd_field=9 in the same cycle; next cycle MEM_WB_wr_data=32'h1234, MEM_WB_RegWrite=1.
- RegWrite=1 with rd=0 -> EX_MEM_RegWrite=0 immediately and MEM_WB_RegWrite=0 next cycle.
- Store 32'h5 to address 0x22 (misaligned) -> memory unchanged (load of 0x20 returns its prior value) and MEM_align_err=1 from the next cycle until rst.
- Wrap: store 32'hA5A5A5A5 to address (4<<DMEM_ADDR_W)+8 -> load from 0x8 returns 32'hA5A5A5A5.
- Store 32'h77 to 0x4 with rst asserted on that edge -> after release, a load of 0x4 returns 0 and all MEM_WB outputs read 0 during reset.
